// File: rtl/dir_cmd_queue.sv
// Direction command queue between the PS/2 key decoder and the game logic controller.
// Optional build macro DIR_QUEUE_OVERWRITE_EN: a push into a full queue replaces the tail instead of dropping.
module dir_cmd_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter logic [1:0]  RST_DIR = 2'b11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    dir_in,
  input  logic          dir_vld_in,
  input  logic          mv_in,
  input  logic          clr_in,
  output logic [1:0]    cur_dir_out,
  output logic [1:0]    head_dir_out,
  output logic [AW:0]   count_out,
  output logic          empty_out,
  output logic          full_out,
  output logic          rej_out,
  output logic          drop_out
);

  localparam int unsigned CW = AW + 1;

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic [1:0]    cur_dir_q;
  logic          empty_q, full_q, rej_q, drop_q;

  logic [AW-1:0] rd_ptr_d, wr_ptr_d, tail_ptr;
  logic [AW:0]   count_d;
  logic [1:0]    cur_dir_d, ref_dir;
  logic          empty_d, full_d, rej_d, drop_d;
  logic          is_full, is_empty, pop_ok, push_req, filter_hit, push_ok;
  logic          mem_we;
  logic [AW-1:0] mem_wa;

  // Filter reference and push/pop qualification, all sampled before this cycle's pop.
  always_comb begin
    tail_ptr = wr_ptr_q - AW'(1);
    is_full  = (count_q == CW'(DEPTH));
    is_empty = (count_q == '0);
    pop_ok   = mv_in && !is_empty && !clr_in;
    push_req = dir_vld_in && !clr_in;
`ifdef DIR_QUEUE_OVERWRITE_EN
    // An overwrite replaces the tail, so it is filtered against the entry before the tail.
    if (is_empty)
      ref_dir = cur_dir_q;
    else if (is_full && !pop_ok)
      ref_dir = mem_q[wr_ptr_q - AW'(2)];
    else
      ref_dir = mem_q[tail_ptr];
`else
    ref_dir = is_empty ? cur_dir_q : mem_q[tail_ptr];
`endif
    filter_hit = (dir_in == ref_dir) || (dir_in == (ref_dir ^ 2'b01));
    push_ok    = push_req && !filter_hit && (!is_full || pop_ok);
  end

  // Next-state computation for pointers, count, committed direction and status.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    cur_dir_d = cur_dir_q;
    rej_d     = 1'b0;
    drop_d    = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = wr_ptr_q;

    if (clr_in) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      cur_dir_d = RST_DIR;
    end else begin
      rej_d = push_req && filter_hit;
`ifdef DIR_QUEUE_OVERWRITE_EN
      if (push_req && !filter_hit && is_full && !pop_ok) begin
        mem_we = 1'b1;
        mem_wa = tail_ptr;
      end
`else
      drop_d = push_req && !filter_hit && is_full && !pop_ok;
`endif
      if (push_ok) begin
        mem_we   = 1'b1;
        mem_wa   = wr_ptr_q;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        cur_dir_d = mem_q[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 2'b00;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      cur_dir_q <= RST_DIR;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rej_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      if (mem_we) mem_q[mem_wa] <= dir_in;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      cur_dir_q <= cur_dir_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      rej_q     <= rej_d;
      drop_q    <= drop_d;
    end
  end

  assign cur_dir_out  = cur_dir_q;
  assign head_dir_out = mem_q[rd_ptr_q];
  assign count_out    = count_q;
  assign empty_out    = empty_q;
  assign full_out     = full_q;
  assign rej_out      = rej_q;
  assign drop_out     = drop_q;

endmodule

// File: tb/tb_dir_cmd_queue.sv
// Table-driven bench for dir_cmd_queue with hand-computed expectations (macro-aware).
module tb_dir_cmd_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dir_in;
  logic       dir_vld_in, mv_in, clr_in;
  logic [1:0] cur_dir_out, head_dir_out;
  logic [2:0] count_out;
  logic       empty_out, full_out, rej_out, drop_out;

  int checks   = 0;
  int failures = 0;

`ifdef DIR_QUEUE_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  dir_cmd_queue dut (
    .clk(clk), .rst_n(rst_n), .dir_in(dir_in), .dir_vld_in(dir_vld_in),
    .mv_in(mv_in), .clr_in(clr_in), .cur_dir_out(cur_dir_out),
    .head_dir_out(head_dir_out), .count_out(count_out), .empty_out(empty_out),
    .full_out(full_out), .rej_out(rej_out), .drop_out(drop_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [1:0] dir;
    logic       mv;
    logic       clr;
    logic [1:0] cur;
    logic [2:0] cnt;
    logic       emp;
    logic       full;
    logic       rej;
    logic       drop;
    logic [1:0] head;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic vld, input logic [1:0] dir, input logic mv,
                              input logic clr, input logic [1:0] cur, input logic [2:0] cnt,
                              input logic emp, input logic full, input logic rej,
                              input logic drop, input logic [1:0] head);
    vec_t v;
    v.vld = vld; v.dir = dir; v.mv = mv; v.clr = clr; v.cur = cur; v.cnt = cnt;
    v.emp = emp; v.full = full; v.rej = rej; v.drop = drop; v.head = head;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string name, input logic [1:0] cur, input logic [2:0] cnt,
                            input logic emp, input logic full, input logic rej, input logic drop);
    chk(name, 16'({cur_dir_out, count_out, empty_out, full_out, rej_out, drop_out}),
        16'({cur, cnt, emp, full, rej, drop}));
  endtask

  task automatic drive(input logic vld, input logic [1:0] dir, input logic mv, input logic clr);
    dir_vld_in = vld; dir_in = dir; mv_in = mv; clr_in = clr;
  endtask

  logic [1:0] t_dir;

  initial begin
    t_dir = OVW ? 2'b01 : 2'b00;
    // vld dir  mv clr | cur  cnt emp full rej drop head
    vecs[0]  = mk(0, 2'b00, 0, 0, 2'b11, 3'd0, 1, 0, 0, 0, 2'b00);
    vecs[1]  = mk(1, 2'b00, 0, 0, 2'b11, 3'd1, 0, 0, 0, 0, 2'b00);
    vecs[2]  = mk(1, 2'b10, 0, 0, 2'b11, 3'd2, 0, 0, 0, 0, 2'b00);
    vecs[3]  = mk(0, 2'b00, 0, 0, 2'b11, 3'd2, 0, 0, 0, 0, 2'b00);
    vecs[4]  = mk(0, 2'b00, 1, 0, 2'b00, 3'd1, 0, 0, 0, 0, 2'b10);
    vecs[5]  = mk(0, 2'b00, 0, 0, 2'b00, 3'd1, 0, 0, 0, 0, 2'b10);
    vecs[6]  = mk(0, 2'b00, 1, 0, 2'b10, 3'd0, 1, 0, 0, 0, 2'b00);
    vecs[7]  = mk(0, 2'b00, 1, 0, 2'b10, 3'd0, 1, 0, 0, 0, 2'b00);
    vecs[8]  = mk(1, 2'b11, 0, 0, 2'b10, 3'd0, 1, 0, 1, 0, 2'b00);
    vecs[9]  = mk(1, 2'b10, 0, 0, 2'b10, 3'd0, 1, 0, 1, 0, 2'b00);
    vecs[10] = mk(0, 2'b00, 0, 0, 2'b10, 3'd0, 1, 0, 0, 0, 2'b00);
    vecs[11] = mk(1, 2'b00, 0, 0, 2'b10, 3'd1, 0, 0, 0, 0, 2'b00);
    vecs[12] = mk(1, 2'b01, 0, 0, 2'b10, 3'd1, 0, 0, 1, 0, 2'b00);
    vecs[13] = mk(1, 2'b00, 0, 0, 2'b10, 3'd1, 0, 0, 1, 0, 2'b00);
    vecs[14] = mk(0, 2'b00, 1, 0, 2'b00, 3'd0, 1, 0, 0, 0, 2'b00);
    // fill with wrap: 10,01,11,00
    vecs[15] = mk(1, 2'b10, 0, 0, 2'b00, 3'd1, 0, 0, 0, 0, 2'b10);
    vecs[16] = mk(1, 2'b01, 0, 0, 2'b00, 3'd2, 0, 0, 0, 0, 2'b10);
    vecs[17] = mk(1, 2'b11, 0, 0, 2'b00, 3'd3, 0, 0, 0, 0, 2'b10);
    vecs[18] = mk(1, 2'b00, 0, 0, 2'b00, 3'd4, 0, 1, 0, 0, 2'b10);
    // push into full queue: dropped, or overwrites tail 00 with 01
    vecs[19] = mk(1, OVW ? 2'b01 : 2'b10, 0, 0, 2'b00, 3'd4, 0, 1, 0, !OVW, 2'b10);
    vecs[20] = mk(0, 2'b00, 0, 0, 2'b00, 3'd4, 0, 1, 0, 0, 2'b10);
    vecs[21] = mk(1, 2'b11, 1, 0, 2'b10, 3'd4, 0, 1, 0, 0, 2'b01);
    vecs[22] = mk(0, 2'b00, 1, 0, 2'b01, 3'd3, 0, 0, 0, 0, 2'b11);
    vecs[23] = mk(0, 2'b00, 1, 0, 2'b11, 3'd2, 0, 0, 0, 0, t_dir);
    vecs[24] = mk(0, 2'b00, 1, 0, t_dir, 3'd1, 0, 0, 0, 0, 2'b11);
    vecs[25] = mk(0, 2'b00, 1, 0, 2'b11, 3'd0, 1, 0, 0, 0, 2'b00);
    // clear with simultaneous push (would be rejected) and pop
    vecs[26] = mk(1, 2'b00, 0, 0, 2'b11, 3'd1, 0, 0, 0, 0, 2'b00);
    vecs[27] = mk(1, 2'b10, 0, 0, 2'b11, 3'd2, 0, 0, 0, 0, 2'b00);
    vecs[28] = mk(1, 2'b01, 0, 0, 2'b11, 3'd3, 0, 0, 0, 0, 2'b00);
    vecs[29] = mk(0, 2'b00, 1, 0, 2'b00, 3'd2, 0, 0, 0, 0, 2'b10);
    vecs[30] = mk(1, 2'b11, 0, 0, 2'b00, 3'd3, 0, 0, 0, 0, 2'b10);
    vecs[31] = mk(1, 2'b11, 1, 1, 2'b11, 3'd0, 1, 0, 0, 0, 2'b00);
    vecs[32] = mk(1, 2'b00, 0, 0, 2'b11, 3'd1, 0, 0, 0, 0, 2'b00);
    vecs[33] = mk(1, 2'b10, 0, 0, 2'b11, 3'd2, 0, 0, 0, 0, 2'b00);

    drive(0, 2'b00, 0, 0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_status("reset_status", 2'b11, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_head", 16'(head_dir_out), 16'(2'b00));
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].vld, vecs[i].dir, vecs[i].mv, vecs[i].clr);
      @(posedge clk);
      #1;
      chk_status($sformatf("vec%0d_status", i), vecs[i].cur, vecs[i].cnt, vecs[i].emp,
                 vecs[i].full, vecs[i].rej, vecs[i].drop);
      if (!vecs[i].emp)
        chk($sformatf("vec%0d_head", i), 16'(head_dir_out), 16'(vecs[i].head));
    end

    // asynchronous reset mid-queue, checked between clock edges
    drive(0, 2'b00, 1, 0);
    @(posedge clk);
    #1;
    drive(0, 2'b00, 0, 0);
    chk_status("pre_async_rst", 2'b00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_status("async_rst_status", 2'b11, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("async_rst_head", 16'(head_dir_out), 16'(2'b00));
    @(negedge clk);
    rst_n = 1'b1;

    // pointers restart at zero after reset
    drive(1, 2'b01, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 2'b00, 0, 0);
    chk_status("post_rst_push", 2'b11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_head", 16'(head_dir_out), 16'(2'b01));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
